// File: rtl/draw_pkg.sv
// draw_pkg: screen geometry, coordinate widths, arbiter states and requester ids
package draw_pkg;
  localparam int X_SCREEN_PIXELS = 160;
  localparam int Y_SCREEN_PIXELS = 120;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int REQ_CLEAR  = 0;
  localparam int REQ_ROCKET = 1;
  localparam int REQ_ALIEN  = 2;
  localparam int REQ_BULLET = 3;
  typedef enum logic [1:0] {IDLE, OWN, GAP} arb_state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vga_draw_arbiter_if.sv
// vga_draw_arbiter_if: requester bundle in, single VGA write port and status out
interface vga_draw_arbiter_if
  import draw_pkg::*;
#(parameter int N_REQ = 4);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    done;
  logic [XW*N_REQ-1:0] x_in;
  logic [YW*N_REQ-1:0] y_in;
  logic [CW*N_REQ-1:0] colour_in;
  logic [N_REQ-1:0]    plot_in;
  logic [N_REQ-1:0]    grant;
  logic [XW-1:0]       xout;
  logic [YW-1:0]       yout;
  logic [CW-1:0]       colourOut;
  logic                plot;
  logic                busy;
  logic                timeout_err;
  modport master (
    output req, done, x_in, y_in, colour_in, plot_in,
    input  grant, xout, yout, colourOut, plot, busy, timeout_err
  );
  modport slave (
    input  req, done, x_in, y_in, colour_in, plot_in,
    output grant, xout, yout, colourOut, plot, busy, timeout_err
  );
endinterface

// File: rtl/vga_draw_arbiter_rr_pick.sv
// rr_pick: first set request bit at or after ptr, wrapping modulo N_REQ
module rr_pick
  import draw_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);
  // Scan farthest offset first so the nearest set bit overwrites the result last.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = |req;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N_REQ]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N_REQ] = 1'b1;
        idx = IW'((int'(ptr) + k) % N_REQ);
      end
    end
  end
endmodule

// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: round-robin owner of the VGA write port with watchdog and
// registered pixel forwarding from the granted drawing engine.
module vga_draw_arbiter
  import draw_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 20000,
  parameter int TW      = 15
) (
  input logic clk,
  input logic reset,
  vga_draw_arbiter_if.slave bus
);
  localparam int IW = idx_w(N_REQ);
  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d, pick_gnt;
  logic [IW-1:0]    idx_q, idx_d, ptr_q, ptr_d, pick_idx;
  logic             pick_any;
  logic [TW-1:0]    wdog_q, wdog_d;
  logic [XW-1:0]    xout_q, xout_d;
  logic [YW-1:0]    yout_q, yout_d;
  logic [CW-1:0]    colour_q, colour_d;
  logic             plot_q, plot_d, busy_q, busy_d, err_q, err_d;
  logic             own_done, own_req, tmo;
  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req(bus.req),
    .ptr(ptr_q),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );
  assign own_done = bus.done[idx_q];
  assign own_req  = bus.req[idx_q];
  assign tmo      = wdog_q == TW'(TIMEOUT - 1);
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    wdog_d   = wdog_q;
    xout_d   = xout_q;
    yout_d   = yout_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    busy_d   = busy_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (pick_any) begin
        state_d = OWN;
        grant_d = pick_gnt;
        idx_d   = pick_idx;
        busy_d  = 1'b1;
        wdog_d  = '0;
      end
      OWN: begin
        xout_d   = bus.x_in[idx_q*XW +: XW];
        yout_d   = bus.y_in[idx_q*YW +: YW];
        colour_d = bus.colour_in[idx_q*CW +: CW];
        plot_d   = bus.plot_in[idx_q];
        wdog_d   = wdog_q + 1'b1;
        // done outranks abandon, which outranks the watchdog; only the last flags an error
        if (own_done || !own_req || tmo) begin
          plot_d  = bus.plot_in[idx_q] & own_done;
          state_d = GAP;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
          err_d   = err_q | (!own_done && own_req);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      wdog_q   <= '0;
      xout_q   <= '0;
      yout_q   <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      wdog_q   <= wdog_d;
      xout_q   <= xout_d;
      yout_q   <= yout_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end
  assign bus.grant       = grant_q;
  assign bus.xout        = xout_q;
  assign bus.yout        = yout_q;
  assign bus.colourOut   = colour_q;
  assign bus.plot        = plot_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb_vga_draw_arbiter: directed and random stimulus against an ownership-level reference model
module tb_vga_draw_arbiter;
  import draw_pkg::*;
  localparam int N  = 4;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  vga_draw_arbiter_if #(.N_REQ(N)) bus();
  vga_draw_arbiter #(.N_REQ(N), .TIMEOUT(TO), .TW(15)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  int errors = 0;
  int checks = 0;
  int owner = -1, cool = 0, held = 0, ptr = 0;
  logic [7:0] ex;
  logic [6:0] ey;
  logic [2:0] ec;
  logic ep, eerr;
  int gseq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: who owns the port, how long they have held it, and a one-cycle cool-down.
  task automatic model_edge();
    if (!reset) begin
      owner = -1; cool = 0; held = 0; ptr = 0;
      ex = '0; ey = '0; ec = '0; ep = 1'b0; eerr = 1'b0;
    end else if (owner >= 0) begin
      ex = bus.x_in[owner*8 +: 8];
      ey = bus.y_in[owner*7 +: 7];
      ec = bus.colour_in[owner*3 +: 3];
      held++;
      if (bus.done[owner] || !bus.req[owner] || held == TO) begin
        ep = bus.plot_in[owner] && bus.done[owner];
        if (!bus.done[owner] && bus.req[owner]) eerr = 1'b1;
        ptr = (owner + 1) % N;
        owner = -1;
        cool = 1;
      end else ep = bus.plot_in[owner];
    end else if (cool > 0) begin
      cool--;
      ep = 1'b0;
    end else begin
      ep = 1'b0;
      for (int k = 0; k < N; k++)
        if (owner < 0 && bus.req[(ptr + k) % N]) begin
          owner = (ptr + k) % N;
          held = 0;
          gseq.push_back(owner);
        end
    end
  endtask

  task automatic cyc();
    logic [3:0] eg;
    model_edge();
    @(posedge clk);
    #1;
    eg = (owner >= 0) ? 4'(1 << owner) : 4'b0;
    chk("grant", 32'(bus.grant), 32'(eg));
    chk("busy", 32'(bus.busy), 32'(owner >= 0));
    chk("xout", 32'(bus.xout), 32'(ex));
    chk("yout", 32'(bus.yout), 32'(ey));
    chk("colour", 32'(bus.colourOut), 32'(ec));
    chk("plot", 32'(bus.plot), 32'(ep));
    chk("timeout_err", 32'(bus.timeout_err), 32'(eerr));
  endtask

  task automatic rst_pulse();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  task automatic wait_owner(input int lim);
    for (int i = 0; i < lim && owner < 0; i++) cyc();
  endtask

  task automatic set_px(input int i, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    bus.x_in[i*8 +: 8] = x;
    bus.y_in[i*7 +: 7] = y;
    bus.colour_in[i*3 +: 3] = c;
  endtask

  initial begin
    bus.req = '0; bus.done = '0; bus.plot_in = '0;
    bus.x_in = '0; bus.y_in = '0; bus.colour_in = '0;
    // reset held with all requesters active
    bus.req = 4'b1111;
    cyc();
    cyc();
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_err", 32'(bus.timeout_err), 32'h0);
    reset = 1'b1;
    cyc();
    chk("first_grant", 32'(bus.grant), 32'h1);
    // round robin with done on the fifth owned cycle
    gseq.delete();
    for (int i = 0; i < 40; i++) begin
      bus.done = (owner >= 0 && held == 4) ? 4'(1 << owner) : 4'b0;
      cyc();
    end
    bus.done = '0;
    chk("rr_count", 32'(gseq.size() >= 4), 32'h1);
    if (gseq.size() >= 4) begin
      chk("rr_seq0", 32'(dut.bus.grant === bus.grant ? gseq[0] : -1), 32'h1);
      chk("rr_seq1", 32'(gseq[1]), 32'h2);
      chk("rr_seq2", 32'(gseq[2]), 32'h3);
      chk("rr_seq3", 32'(gseq[3]), 32'h0);
    end
    // skip idle requester 3 and wrap to 0
    rst_pulse();
    bus.req = 4'b0100;
    wait_owner(10);
    chk("skip_own2", 32'(bus.grant), 32'h4);
    bus.done = 4'b0100;
    cyc();
    bus.done = '0;
    bus.req = 4'b0011;
    wait_owner(10);
    chk("skip_grant", 32'(bus.grant), 32'h1);
    bus.done = 4'b0001;
    cyc();
    bus.done = '0;
    wait_owner(10);
    chk("skip_next", 32'(bus.grant), 32'h2);
    // forwarding: requester 2 strobes concurrently but is not granted
    rst_pulse();
    bus.req = 4'b0110;
    bus.plot_in = 4'b0110;
    set_px(1, 8'd73, 7'd105, 3'b110);
    set_px(2, 8'd10, 7'd20, 3'b001);
    wait_owner(10);
    cyc();
    chk("fwd_x", 32'(bus.xout), 32'd73);
    chk("fwd_y", 32'(bus.yout), 32'd105);
    chk("fwd_c", 32'(bus.colourOut), 32'd6);
    chk("fwd_plot", 32'(bus.plot), 32'h1);
    for (int i = 0; i < 6; i++) cyc();
    chk("fwd_x_hold", 32'(bus.xout), 32'd73);
    bus.plot_in = '0;
    // watchdog revokes a grant that never completes
    rst_pulse();
    bus.req = 4'b0001;
    for (int i = 0; i < 40 && !eerr; i++) cyc();
    chk("wd_err", 32'(bus.timeout_err), 32'h1);
    chk("wd_drop", 32'(bus.grant), 32'h0);
    bus.req = 4'b0011;
    wait_owner(10);
    chk("wd_next", 32'(bus.grant), 32'h2);
    for (int i = 0; i < 5; i++) cyc();
    chk("wd_sticky", 32'(bus.timeout_err), 32'h1);
    // mid-grant abandon, then reset during ownership
    rst_pulse();
    bus.req = 4'b0100;
    bus.plot_in = 4'b0100;
    wait_owner(10);
    for (int i = 0; i < 3; i++) cyc();
    bus.req = '0;
    cyc();
    chk("abandon_grant", 32'(bus.grant), 32'h0);
    chk("abandon_busy", 32'(bus.busy), 32'h0);
    bus.req = 4'b0100;
    wait_owner(10);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    chk("rst_own_grant", 32'(bus.grant), 32'h0);
    chk("rst_own_plot", 32'(bus.plot), 32'h0);
    reset = 1'b1;
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.req = 4'($urandom);
      bus.done = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
      bus.plot_in = 4'($urandom);
      bus.x_in = 32'($urandom);
      bus.y_in = 28'($urandom);
      bus.colour_in = 12'($urandom);
      reset = ($urandom_range(0, 299) != 0);
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
